// File: rtl/eq_pkg.sv
// Shared types and defaults for the histogram-equalization frame sequencer.
package eq_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_CNT_W  = 20;

  // Smallest legal divisor; substituted when CdfMin leaves no dynamic range.
  localparam int unsigned DIV_FLOOR = 1;

  typedef enum logic [2:0] {
    IDLE,
    HIST,
    CDF,
    CALC,
    OUT,
    FDONE
  } eqState_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HIST,
    OWN_CDF
  } m2Owner_t;

endpackage

// File: rtl/m2_write_arbiter.sv
// Owner-select mux for the single M2 write port; non-owner requests are dropped.
module m2_write_arbiter
  import eq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  m2Owner_t          owner,
  input  logic              hist_m2_we,
  input  logic [ADDR_W-1:0] hist_m2_addr,
  input  logic [DATA_W-1:0] hist_m2_data,
  input  logic              cdf_m2_we,
  input  logic [ADDR_W-1:0] cdf_m2_addr,
  input  logic [DATA_W-1:0] cdf_m2_data,
  output logic              m2_WriteEnable,
  output logic [ADDR_W-1:0] m2_WriteAddress,
  output logic [DATA_W-1:0] m2_WriteBus
);

  always_comb begin
    m2_WriteEnable  = 1'b0;
    m2_WriteAddress = '0;
    m2_WriteBus     = '0;
    unique case (owner)
      OWN_HIST: begin
        m2_WriteEnable  = hist_m2_we;
        m2_WriteAddress = hist_m2_addr;
        m2_WriteBus     = hist_m2_data;
      end
      OWN_CDF: begin
        m2_WriteEnable  = cdf_m2_we;
        m2_WriteAddress = cdf_m2_addr;
        m2_WriteBus     = cdf_m2_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eq_frame_sequencer.sv
// Per-frame controller: histogram -> CDF -> divisor calc -> output, with M2 write arbitration.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module eq_frame_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter logic        OFFSET_INIT    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  frame_pixels,
  output logic              hist_start,
  input  logic              hist_done,
  output logic              cdf_start,
  input  logic              cdf_done,
  input  logic [CNT_W-1:0]  cdf_min_in,
  output logic              out_start,
  input  logic              out_done,
  output logic [CNT_W-1:0]  CdfMin,
  output logic [CNT_W-1:0]  divisor,
  output logic              output_base_offset,
  input  logic              hist_m2_we,
  input  logic [ADDR_W-1:0] hist_m2_addr,
  input  logic [DATA_W-1:0] hist_m2_data,
  input  logic              cdf_m2_we,
  input  logic [ADDR_W-1:0] cdf_m2_addr,
  input  logic [DATA_W-1:0] cdf_m2_data,
  output logic              m2_WriteEnable,
  output logic [ADDR_W-1:0] m2_WriteAddress,
  output logic [DATA_W-1:0] m2_WriteBus,
  output logic              busy,
  output logic              frame_done,
`ifdef STAGE_TIMEOUT_EN
  output logic              stage_timeout,
`endif
  output logic              div_err
);

  eqState_t         state, nextState;
  logic             firstCycle;
  logic             histAccept, cdfAccept, outAccept;
  logic             stageTimeout;
  logic [CNT_W-1:0] pixLatched;
  m2Owner_t         owner;

  // Stage dones count only after the start cycle, so a done coincident with start is dropped.
  always_comb begin
    histAccept = (state == HIST) && hist_done && !firstCycle;
    cdfAccept  = (state == CDF)  && cdf_done  && !firstCycle;
    outAccept  = (state == OUT)  && out_done  && !firstCycle;
  end

`ifdef STAGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stageCnt;
  logic            inStage;

  always_comb begin
    inStage      = (state == HIST) || (state == CDF) || (state == OUT);
    stageTimeout = inStage && (stageCnt == TO_W'(TIMEOUT_CYCLES - 1));
    stage_timeout = stageTimeout;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stageCnt <= '0;
    end else if (!inStage || (nextState != state)) begin
      stageCnt <= '0;
    end else begin
      stageCnt <= stageCnt + 1'b1;
    end
  end
`else
  always_comb stageTimeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      firstCycle <= 1'b0;
    end else begin
      state      <= nextState;
      firstCycle <= (nextState != state);
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (frame_start) nextState = HIST;
      HIST:  if (histAccept) nextState = CDF;
             else if (stageTimeout) nextState = IDLE;
      CDF:   if (cdfAccept) nextState = CALC;
             else if (stageTimeout) nextState = IDLE;
      CALC:  nextState = OUT;
      OUT:   if (outAccept) nextState = FDONE;
             else if (stageTimeout) nextState = IDLE;
      FDONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    hist_start = (state == HIST) && firstCycle;
    cdf_start  = (state == CDF)  && firstCycle;
    out_start  = (state == OUT)  && firstCycle;
    busy       = (state != IDLE);
    frame_done = (state == FDONE);
    unique case (state)
      HIST:    owner = OWN_HIST;
      CDF:     owner = OWN_CDF;
      default: owner = OWN_NONE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixLatched         <= '0;
      CdfMin             <= '0;
      divisor            <= CNT_W'(DIV_FLOOR);
      div_err            <= 1'b0;
      output_base_offset <= OFFSET_INIT;
    end else begin
      if ((state == IDLE) && frame_start) begin
        pixLatched <= frame_pixels;
        div_err    <= 1'b0;
      end
      if (cdfAccept) begin
        CdfMin <= cdf_min_in;
      end
      if (state == CALC) begin
        if (CdfMin >= pixLatched) begin
          divisor <= CNT_W'(DIV_FLOOR);
          div_err <= 1'b1;
        end else begin
          divisor <= pixLatched - CdfMin;
        end
      end
      if (state == FDONE) begin
        output_base_offset <= ~output_base_offset;
      end
    end
  end

  m2_write_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_m2Arb (
    .owner          (owner),
    .hist_m2_we     (hist_m2_we),
    .hist_m2_addr   (hist_m2_addr),
    .hist_m2_data   (hist_m2_data),
    .cdf_m2_we      (cdf_m2_we),
    .cdf_m2_addr    (cdf_m2_addr),
    .cdf_m2_data    (cdf_m2_data),
    .m2_WriteEnable (m2_WriteEnable),
    .m2_WriteAddress(m2_WriteAddress),
    .m2_WriteBus    (m2_WriteBus)
  );

endmodule

// File: tb/tb_eq_frame_sequencer.sv
// Directed self-checking bench for eq_frame_sequencer; both M2 requesters write every cycle.
module tb_eq_frame_sequencer;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 20;

  localparam logic [ADDR_W-1:0] HA = 16'h0010;
  localparam logic [ADDR_W-1:0] CA = 16'h0020;
  localparam logic [DATA_W-1:0] HD = 128'hA5A5_0001_0000_0000_0000_0000_0000_1111;
  localparam logic [DATA_W-1:0] CD = 128'h5A5A_0002_0000_0000_0000_0000_0000_2222;

  localparam int P_IDLE  = 0;
  localparam int P_HIST  = 1;
  localparam int P_CDF   = 2;
  localparam int P_OTHER = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_start = 1'b0;
  logic [CNT_W-1:0]  frame_pixels = '0;
  logic              hist_start, cdf_start, out_start;
  logic              hist_done = 1'b0, cdf_done = 1'b0, out_done = 1'b0;
  logic [CNT_W-1:0]  cdf_min_in = '0;
  logic [CNT_W-1:0]  CdfMin, divisor;
  logic              output_base_offset;
  logic              hist_m2_we = 1'b1, cdf_m2_we = 1'b1;
  logic [ADDR_W-1:0] hist_m2_addr = HA, cdf_m2_addr = CA;
  logic [DATA_W-1:0] hist_m2_data = HD, cdf_m2_data = CD;
  logic              m2_WriteEnable;
  logic [ADDR_W-1:0] m2_WriteAddress;
  logic [DATA_W-1:0] m2_WriteBus;
  logic              busy, frame_done, div_err;
`ifdef STAGE_TIMEOUT_EN
  logic              stage_timeout;
`endif

  int vectors = 0;
  int miscompares = 0;
  int stepIdx = 0;
  int histPulses = 0, cdfPulses = 0, outPulses = 0, doneCnt = 0, busyCnt = 0;
  int histOwn = 0, cdfOwn = 0, badWe = 0;
  int histIdx = 0, cdfIdx = 0, outIdx = 0, doneIdx = 0;

  always #5 clock = ~clock;

  eq_frame_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W(CNT_W),
    .OFFSET_INIT(1'b0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .frame_start       (frame_start),
    .frame_pixels      (frame_pixels),
    .hist_start        (hist_start),
    .hist_done         (hist_done),
    .cdf_start         (cdf_start),
    .cdf_done          (cdf_done),
    .cdf_min_in        (cdf_min_in),
    .out_start         (out_start),
    .out_done          (out_done),
    .CdfMin            (CdfMin),
    .divisor           (divisor),
    .output_base_offset(output_base_offset),
    .hist_m2_we        (hist_m2_we),
    .hist_m2_addr      (hist_m2_addr),
    .hist_m2_data      (hist_m2_data),
    .cdf_m2_we         (cdf_m2_we),
    .cdf_m2_addr       (cdf_m2_addr),
    .cdf_m2_data       (cdf_m2_data),
    .m2_WriteEnable    (m2_WriteEnable),
    .m2_WriteAddress   (m2_WriteAddress),
    .m2_WriteBus       (m2_WriteBus),
    .busy              (busy),
    .frame_done        (frame_done),
`ifdef STAGE_TIMEOUT_EN
    .stage_timeout     (stage_timeout),
`endif
    .div_err           (div_err)
  );

  // Advance one cycle and tally pulses / write-port ownership against the phase the bench expects.
  task automatic step(input int ph);
    @(negedge clock);
    stepIdx++;
    if (hist_start) begin histPulses++; histIdx = stepIdx; end
    if (cdf_start)  begin cdfPulses++;  cdfIdx  = stepIdx; end
    if (out_start)  begin outPulses++;  outIdx  = stepIdx; end
    if (frame_done) begin doneCnt++;    doneIdx = stepIdx; end
    if (busy) busyCnt++;
    if (m2_WriteEnable) begin
      if (ph == P_HIST && m2_WriteAddress == HA && m2_WriteBus == HD) histOwn++;
      else if (ph == P_CDF && m2_WriteAddress == CA && m2_WriteBus == CD) cdfOwn++;
      else badWe++;
    end else if (ph != P_HIST && ph != P_CDF &&
                 (m2_WriteAddress != '0 || m2_WriteBus != '0)) begin
      badWe++;
    end
  endtask

  // Fixed-length frame: each done 5 cycles after its start; spur adds misplaced handshakes.
  task automatic doFrame(input logic [CNT_W-1:0] pix, input logic [CNT_W-1:0] mn,
                         input bit spur, output logic errAtHist);
    frame_pixels = pix;
    frame_start  = 1'b1;
    step(P_HIST);
    frame_start = 1'b0;
    errAtHist   = div_err;
    if (spur) hist_done = 1'b1;
    step(P_HIST);
    hist_done = 1'b0;
    if (spur) out_done = 1'b1;
    step(P_HIST);
    out_done = 1'b0;
    step(P_HIST);
    step(P_HIST);
    hist_done = 1'b1;
    step(P_CDF);
    hist_done = 1'b0;
    repeat (4) step(P_CDF);
    cdf_done   = 1'b1;
    cdf_min_in = mn;
    step(P_OTHER);
    cdf_done = 1'b0;
    step(P_OTHER);
    step(P_OTHER);
    if (spur) frame_start = 1'b1;
    step(P_OTHER);
    frame_start = 1'b0;
    step(P_OTHER);
    step(P_OTHER);
    out_done = 1'b1;
    step(P_OTHER);
    out_done = 1'b0;
    step(P_IDLE);
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if ({hist_start, cdf_start, out_start} !== 3'b000) begin miscompares++; $display("FAIL rst_starts got %b want 000", {hist_start, cdf_start, out_start}); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL rst_div_err got %b want 0", div_err); end
    vectors++; if (m2_WriteEnable !== 1'b0) begin miscompares++; $display("FAIL rst_m2_we got %b want 0", m2_WriteEnable); end
    vectors++; if (CdfMin !== 20'd0) begin miscompares++; $display("FAIL rst_cdfmin got %0d want 0", CdfMin); end
    vectors++; if (divisor !== 20'd1) begin miscompares++; $display("FAIL rst_divisor got %0d want 1", divisor); end
    vectors++; if (output_base_offset !== 1'b0) begin miscompares++; $display("FAIL rst_offset got %b want 0", output_base_offset); end
    reset = 1'b0;
    step(P_IDLE);
    step(P_IDLE);
  endtask

  task automatic test_nominal();
    int base;
    logic e;
    base = stepIdx;
    histPulses = 0; cdfPulses = 0; outPulses = 0; doneCnt = 0; busyCnt = 0;
    doFrame(20'd64, 20'd1, 1'b0, e);
    vectors++; if (histPulses !== 1) begin miscompares++; $display("FAIL nom_hist_pulses got %0d want 1", histPulses); end
    vectors++; if (cdfPulses !== 1) begin miscompares++; $display("FAIL nom_cdf_pulses got %0d want 1", cdfPulses); end
    vectors++; if (outPulses !== 1) begin miscompares++; $display("FAIL nom_out_pulses got %0d want 1", outPulses); end
    vectors++; if (doneCnt !== 1) begin miscompares++; $display("FAIL nom_frame_done got %0d want 1", doneCnt); end
    vectors++; if (histIdx - base !== 1) begin miscompares++; $display("FAIL nom_hist_time got %0d want 1", histIdx - base); end
    vectors++; if (cdfIdx - base !== 6) begin miscompares++; $display("FAIL nom_cdf_time got %0d want 6", cdfIdx - base); end
    vectors++; if (outIdx - base !== 12) begin miscompares++; $display("FAIL nom_out_time got %0d want 12", outIdx - base); end
    vectors++; if (doneIdx - base !== 17) begin miscompares++; $display("FAIL nom_done_time got %0d want 17", doneIdx - base); end
    vectors++; if (busyCnt !== 17) begin miscompares++; $display("FAIL nom_busy_cycles got %0d want 17", busyCnt); end
    vectors++; if (CdfMin !== 20'd1) begin miscompares++; $display("FAIL nom_cdfmin got %0d want 1", CdfMin); end
    vectors++; if (divisor !== 20'd63) begin miscompares++; $display("FAIL nom_divisor got %0d want 63", divisor); end
    vectors++; if (output_base_offset !== 1'b1) begin miscompares++; $display("FAIL nom_offset got %b want 1", output_base_offset); end
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL nom_div_err got %b want 0", div_err); end
  endtask

  task automatic test_back_to_back();
    int prevDone;
    logic e;
    prevDone = doneIdx;
    doFrame(20'd256, 20'd6, 1'b0, e);
    vectors++; if (histIdx - prevDone !== 2) begin miscompares++; $display("FAIL b2b_restart got %0d want 2", histIdx - prevDone); end
    vectors++; if (output_base_offset !== 1'b0) begin miscompares++; $display("FAIL b2b_offset got %b want 0", output_base_offset); end
    vectors++; if (CdfMin !== 20'd6) begin miscompares++; $display("FAIL b2b_cdfmin got %0d want 6", CdfMin); end
    vectors++; if (divisor !== 20'd250) begin miscompares++; $display("FAIL b2b_divisor got %0d want 250", divisor); end
  endtask

  task automatic test_degenerate();
    logic e;
    doFrame(20'd64, 20'd64, 1'b0, e);
    vectors++; if (divisor !== 20'd1) begin miscompares++; $display("FAIL deg_divisor got %0d want 1", divisor); end
    vectors++; if (div_err !== 1'b1) begin miscompares++; $display("FAIL deg_div_err got %b want 1", div_err); end
    repeat (3) step(P_IDLE);
    vectors++; if (div_err !== 1'b1) begin miscompares++; $display("FAIL deg_div_err_hold got %b want 1", div_err); end
    doFrame(20'd100, 20'd10, 1'b0, e);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL deg_err_clear got %b want 0", e); end
    vectors++; if (divisor !== 20'd90) begin miscompares++; $display("FAIL deg_next_divisor got %0d want 90", divisor); end
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL deg_next_div_err got %b want 0", div_err); end
  endtask

  task automatic test_arbitration();
    logic e;
    histOwn = 0; cdfOwn = 0; badWe = 0;
    doFrame(20'd64, 20'd1, 1'b0, e);
    vectors++; if (histOwn !== 5) begin miscompares++; $display("FAIL arb_hist_cycles got %0d want 5", histOwn); end
    vectors++; if (cdfOwn !== 5) begin miscompares++; $display("FAIL arb_cdf_cycles got %0d want 5", cdfOwn); end
    vectors++; if (badWe !== 0) begin miscompares++; $display("FAIL arb_stray_writes got %0d want 0", badWe); end
    vectors++; if ({m2_WriteEnable, m2_WriteAddress} !== 17'd0) begin miscompares++; $display("FAIL arb_idle_port got %h want 0", {m2_WriteEnable, m2_WriteAddress}); end
  endtask

  task automatic test_spurious();
    logic e;
    logic prevOff;
    prevOff = output_base_offset;
    histPulses = 0; cdfPulses = 0; outPulses = 0; doneCnt = 0; histOwn = 0;
    doFrame(20'd128, 20'd8, 1'b1, e);
    repeat (3) step(P_IDLE);
    vectors++; if (histOwn !== 5) begin miscompares++; $display("FAIL spur_hist_len got %0d want 5", histOwn); end
    vectors++; if ({histPulses, cdfPulses, outPulses} !== {32'd1, 32'd1, 32'd1}) begin miscompares++; $display("FAIL spur_pulses got %0d/%0d/%0d want 1/1/1", histPulses, cdfPulses, outPulses); end
    vectors++; if (doneCnt !== 1) begin miscompares++; $display("FAIL spur_frame_done got %0d want 1", doneCnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL spur_queued_start got %b want 0", busy); end
    vectors++; if (output_base_offset !== ~prevOff) begin miscompares++; $display("FAIL spur_offset got %b want %b", output_base_offset, ~prevOff); end
    vectors++; if (divisor !== 20'd120) begin miscompares++; $display("FAIL spur_divisor got %0d want 120", divisor); end
  endtask

  task automatic test_reset_mid_out();
    logic e;
    int doneBefore;
    doFrame(20'd64, 20'd1, 1'b0, e);
    vectors++; if (output_base_offset !== 1'b1) begin miscompares++; $display("FAIL rmo_pre_offset got %b want 1", output_base_offset); end
    frame_pixels = 20'd64;
    frame_start  = 1'b1;
    step(P_HIST);
    frame_start = 1'b0;
    repeat (4) step(P_HIST);
    hist_done = 1'b1;
    step(P_CDF);
    hist_done = 1'b0;
    repeat (4) step(P_CDF);
    cdf_done   = 1'b1;
    cdf_min_in = 20'd3;
    step(P_OTHER);
    cdf_done = 1'b0;
    step(P_OTHER);
    step(P_OTHER);
    vectors++; if ({busy, CdfMin} !== {1'b1, 20'd3}) begin miscompares++; $display("FAIL rmo_in_out got busy=%b min=%0d want 1/3", busy, CdfMin); end
    doneBefore = doneCnt;
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmo_busy got %b want 0", busy); end
    vectors++; if (output_base_offset !== 1'b0) begin miscompares++; $display("FAIL rmo_offset got %b want 0", output_base_offset); end
    vectors++; if ({CdfMin, divisor} !== {20'd0, 20'd1}) begin miscompares++; $display("FAIL rmo_regs got %0d/%0d want 0/1", CdfMin, divisor); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) step(P_IDLE);
    vectors++; if ({busy, output_base_offset} !== 2'b00) begin miscompares++; $display("FAIL rmo_after got %b want 00", {busy, output_base_offset}); end
    vectors++; if (doneCnt !== doneBefore) begin miscompares++; $display("FAIL rmo_no_done got %0d want %0d", doneCnt, doneBefore); end
  endtask

`ifdef STAGE_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    int doneBefore;
    logic prevOff;
    seen = -1;
    doneBefore = doneCnt;
    prevOff = output_base_offset;
    frame_pixels = 20'd64;
    frame_start  = 1'b1;
    step(P_HIST);
    frame_start = 1'b0;
    if (stage_timeout) seen = 1;
    for (int i = 2; i <= 30; i++) begin
      step(P_HIST);
      if (stage_timeout && seen < 0) seen = i;
    end
    vectors++; if (seen !== 16) begin miscompares++; $display("FAIL to_cycle got %0d want 16", seen); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_idle got %b want 0", busy); end
    vectors++; if (doneCnt !== doneBefore) begin miscompares++; $display("FAIL to_no_done got %0d want %0d", doneCnt, doneBefore); end
    vectors++; if (output_base_offset !== prevOff) begin miscompares++; $display("FAIL to_offset got %b want %b", output_base_offset, prevOff); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_degenerate();
    test_arbitration();
    test_spurious();
    test_reset_mid_out();
`ifdef STAGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
